// File: rtl/jpeg_quant_pkg.sv
// Shared constants and FSM state type for the JPEG quantiser.
package jpeg_quant_pkg;

  localparam int JPEG_BLOCK_SIZE = 64;
  localparam int JPEG_IDX_W      = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_DIV,
    ST_STORE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/jpeg_div_serial.sv
// Serial restoring divider: one quotient bit per cycle, MSB first.
// A start pulse loads the operands. The next DIVIDEND_W cycles each produce one quotient bit.
module jpeg_div_serial #(
  parameter int DIVIDEND_W = 33,
  parameter int DIVISOR_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic [DIVISOR_W:0]    trial;
  logic [DIVISOR_W-1:0]  diff;

  // Shift the next dividend bit into the remainder, then subtract the divisor if it fits.
  // The remainder stays below the divisor, so the low DIVISOR_W bits of the difference are exact.
  always_comb begin
    trial  = {rem_q, quo_q[DIVIDEND_W-1]};
    diff   = trial[DIVISOR_W-1:0] - dvs_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    quo_d  = quo_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start) begin
      rem_d  = '0;
      quo_d  = dividend;
      dvs_d  = divisor;
      cnt_d  = CNT_W'(DIVIDEND_W);
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (trial >= {1'b0, dvs_q}) begin
        rem_d = diff;
        quo_d = {quo_q[DIVIDEND_W-2:0], 1'b1};
      end else begin
        rem_d = trial[DIVISOR_W-1:0];
        quo_d = {quo_q[DIVIDEND_W-2:0], 1'b0};
      end
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) busy_d = 1'b0;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      dvs_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy     = busy_q;
  // done flags the cycle that computes the final bit. The complete quotient is available on the following cycle.
  assign done     = (cnt_q == CNT_W'(1));
  assign quotient = quo_q;

endmodule

// File: rtl/jpeg_quant.sv
// JPEG quantiser. It divides each of the 64 DCT coefficients by its Q entry.
// Rounding is half away from zero, and the result is clamped symmetrically.
module jpeg_quant
  import jpeg_quant_pkg::*;
#(
  parameter int WIDTH_IN  = 32,
  parameter int WIDTH_Q   = 16,
  parameter int WIDTH_OUT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH_IN*64-1:0]     matrix_in_flat,
  input  logic [WIDTH_Q*64-1:0]      quant_flat,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH_OUT*64-1:0]    q_out_flat,
  output logic                       div_zero
);

  localparam int DIVW = WIDTH_IN + 1;
  localparam logic [DIVW-1:0] SAT_MAX = DIVW'((64'd1 << (WIDTH_OUT - 1)) - 64'd1);
  localparam logic [JPEG_IDX_W-1:0] LAST_IDX = JPEG_IDX_W'(JPEG_BLOCK_SIZE - 1);

  state_t                  state_q, state_d;
  logic [JPEG_IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH_IN*64-1:0]  coef_q, coef_d;
  logic [WIDTH_Q*64-1:0]   qtab_q, qtab_d;
  logic                    sign_q, sign_d;
  logic [WIDTH_OUT*64-1:0] qout_q, qout_d;
  logic                    div_zero_q, div_zero_d;
  logic                    out_valid_q, out_valid_d;

  logic [WIDTH_IN-1:0]     cur_x, cur_mag;
  logic [WIDTH_Q-1:0]      cur_q;
  logic [WIDTH_OUT-1:0]    sat_mag, store_val;
  logic                    div_start, div_busy, div_done;
  logic [DIVW-1:0]         div_dividend, div_quotient;

  // Per-coefficient datapath: magnitude plus half-Q rounding offset in, saturate and re-sign out.
  always_comb begin
    cur_x        = coef_q[idx_q*WIDTH_IN +: WIDTH_IN];
    cur_q        = qtab_q[idx_q*WIDTH_Q +: WIDTH_Q];
    cur_mag      = cur_x[WIDTH_IN-1] ? (~cur_x + WIDTH_IN'(1)) : cur_x;
    div_dividend = {1'b0, cur_mag} + DIVW'(cur_q >> 1);
    div_start    = (state_q == ST_SETUP);
    sat_mag      = (div_quotient > SAT_MAX) ? SAT_MAX[WIDTH_OUT-1:0]
                                            : div_quotient[WIDTH_OUT-1:0];
    store_val    = sign_q ? (~sat_mag + WIDTH_OUT'(1)) : sat_mag;
  end

  jpeg_div_serial #(
    .DIVIDEND_W (DIVW),
    .DIVISOR_W  (WIDTH_Q)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (cur_q),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );

  // Block sequencing: capture, then per-coefficient SETUP/DIV/STORE, then hold the result until it is consumed.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    coef_d      = coef_q;
    qtab_d      = qtab_q;
    sign_d      = sign_q;
    qout_d      = qout_q;
    div_zero_d  = div_zero_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          coef_d     = matrix_in_flat;
          qtab_d     = quant_flat;
          idx_d      = '0;
          div_zero_d = 1'b0;
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        sign_d  = cur_x[WIDTH_IN-1];
        state_d = ST_DIV;
      end
      ST_DIV: begin
        if (div_busy && div_done) state_d = ST_STORE;
      end
      ST_STORE: begin
        if (cur_q == '0) begin
          qout_d[idx_q*WIDTH_OUT +: WIDTH_OUT] = '0;
          div_zero_d = 1'b1;
        end else begin
          qout_d[idx_q*WIDTH_OUT +: WIDTH_OUT] = store_val;
        end
        if (idx_q == LAST_IDX) begin
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          idx_d   = idx_q + JPEG_IDX_W'(1);
          state_d = ST_SETUP;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Block state, capture and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      coef_q      <= '0;
      qtab_q      <= '0;
      sign_q      <= 1'b0;
      qout_q      <= '0;
      div_zero_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      coef_q      <= coef_d;
      qtab_q      <= qtab_d;
      sign_q      <= sign_d;
      qout_q      <= qout_d;
      div_zero_q  <= div_zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = out_valid_q;
  assign q_out_flat = qout_q;
  assign div_zero   = div_zero_q;

endmodule

// File: tb/tb_jpeg_quant.sv
// Directed scoreboard bench for jpeg_quant at default parameters.
module tb_jpeg_quant;

  localparam int WI = 32;
  localparam int WQ = 16;
  localparam int WO = 16;
  localparam int N  = 64;
  localparam longint LATENCY = 64 * (WI + 3);

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [WI*N-1:0] matrix_in_flat;
  logic [WQ*N-1:0] quant_flat;
  logic            out_valid;
  logic            out_ready;
  logic [WO*N-1:0] q_out_flat;
  logic            div_zero;

  jpeg_quant #(.WIDTH_IN(WI), .WIDTH_Q(WQ), .WIDTH_OUT(WO)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .matrix_in_flat (matrix_in_flat),
    .quant_flat     (quant_flat),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .q_out_flat     (q_out_flat),
    .div_zero       (div_zero)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  longint acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] coef[N];
  logic [15:0] qt[N];

  typedef struct {
    logic [WO*N-1:0] data;
    logic            dz;
  } exp_t;
  exp_t sb[$];

  // Reference quantiser using native integer division.
  function automatic logic [15:0] model(input logic [31:0] x, input logic [15:0] q);
    longint m, r;
    if (q == 16'd0) return 16'd0;
    m = longint'($signed(x));
    if (m < 0) m = -m;
    r = (m + longint'(q) / 2) / longint'(q);
    if (r > 32767) r = 32767;
    if (x[31]) r = -r;
    return r[15:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_block();
    exp_t e;
    int   n = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_before_accept", 64'(in_ready), 64'd1);
    e.dz = 1'b0;
    for (int i = 0; i < N; i++) begin
      matrix_in_flat[i*WI +: WI] = coef[i];
      quant_flat[i*WQ +: WQ]     = qt[i];
      e.data[i*WO +: WO]         = model(coef[i], qt[i]);
      if (qt[i] == 16'd0) e.dz = 1'b1;
    end
    in_valid = 1'b1;
    @(posedge clk); #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    matrix_in_flat = {64{$urandom}};
    quant_flat     = {32{$urandom}};
    sb.push_back(e);
    chk("in_ready_busy", 64'(in_ready), 64'd0);
  endtask

  task automatic consume(input int hold);
    exp_t e;
    int   n = 0;
    while (out_valid !== 1'b1 && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    chk("out_valid_wait", 64'(out_valid), 64'd1);
    chk("latency", 64'(cyc - acc_cyc), 64'(LATENCY));
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 64'(sb.size()), 64'd1);
      return;
    end
    e = sb.pop_front();
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      if (k % 10 == 0) begin
        chk("hold_out_valid", 64'(out_valid), 64'd1);
        chk("hold_in_ready", 64'(in_ready), 64'd0);
        chk($sformatf("hold_slot%0d", (k / 10) % N),
            64'(q_out_flat[((k / 10) % N)*WO +: WO]), 64'(e.data[((k / 10) % N)*WO +: WO]));
      end
      in_valid = (k % 25 == 5);
      if (in_valid) matrix_in_flat = {64{$urandom}};
    end
    in_valid = 1'b0;
    for (int i = 0; i < N; i++)
      chk($sformatf("slot%0d", i), 64'(q_out_flat[i*WO +: WO]), 64'(e.data[i*WO +: WO]));
    chk("div_zero", 64'(div_zero), 64'(e.dz));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_after_handoff", 64'(out_valid), 64'd0);
    chk("in_ready_after_handoff", 64'(in_ready), 64'd1);
    chk("slot0_stable", 64'(q_out_flat[0 +: WO]), 64'(e.data[0 +: WO]));
    chk("slot63_stable", 64'(q_out_flat[63*WO +: WO]), 64'(e.data[63*WO +: WO]));
    chk("div_zero_stable", 64'(div_zero), 64'(e.dz));
  endtask

  initial begin
    logic [31:0] pat[6];
    bit          seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    matrix_in_flat = '0; quant_flat = '0;

    // Reset held for three cycles.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_div_zero", 64'(div_zero), 64'd0);
    checks++;
    assert (q_out_flat === '0) else begin
      errors++;
      $error("FAIL rst_q_out: observed %0h expected 0", q_out_flat[63:0]);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Rounding: Q = 16 throughout.
    pat[0] = 32'd100; pat[1] = -32'sd100; pat[2] = 32'd8;
    pat[3] = 32'd7;   pat[4] = -32'sd8;   pat[5] = -32'sd7;
    for (int i = 0; i < N; i++) begin
      coef[i] = pat[i % 6];
      qt[i]   = 16'd16;
    end
    send_block();
    consume(0);

    // Saturation at Q = 1; large-Q rounding at Q = 65535.
    for (int i = 0; i < N; i++) begin
      if (i < 32) begin
        coef[i] = (i % 2 == 0) ? 32'h7fff_ffff : 32'h8000_0000;
        qt[i]   = 16'd1;
      end else begin
        case (i % 4)
          0: coef[i] = 32'd32767;
          1: coef[i] = 32'd32768;
          2: coef[i] = -32'sd32768;
          default: coef[i] = -32'sd32767;
        endcase
        qt[i] = 16'hffff;
      end
    end
    send_block();
    consume(0);

    // A zero Q entry in slot 5.
    for (int i = 0; i < N; i++) begin
      coef[i] = 32'd9;
      qt[i]   = (i == 5) ? 16'd0 : 16'd1;
    end
    send_block();
    consume(0);

    // Clean block with output backpressure and ignored input pulses.
    for (int i = 0; i < N; i++) begin
      coef[i] = 32'($urandom_range(0, 4000)) - 32'd2000;
      qt[i]   = 16'($urandom_range(1, 255));
    end
    send_block();
    consume(100);

    // Reset asserted 1000 cycles into a block.
    for (int i = 0; i < N; i++) begin
      coef[i] = $urandom;
      qt[i]   = 16'($urandom_range(1, 65535));
    end
    send_block();
    repeat (999) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_div_zero", 64'(div_zero), 64'd0);
    checks++;
    assert (q_out_flat === '0) else begin
      errors++;
      $error("FAIL midrst_q_out: observed %0h expected 0", q_out_flat[63:0]);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    void'(sb.pop_back());
    seen = 1'b0;
    for (int k = 0; k < 2400; k++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    chk("midrst_no_out_valid", 64'(seen), 64'd0);

    // Mixed block after the abandoned one.
    for (int i = 0; i < N; i++) begin
      coef[i] = (i % 3 == 0) ? $urandom : (32'($urandom_range(0, 100000)) - 32'd50000);
      qt[i]   = (i % 2 == 0) ? 16'($urandom_range(1, 65535)) : 16'($urandom_range(1, 64));
    end
    send_block();
    consume(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
